int_alu_seq: RTL and testbench

INT_ALU_SEQ -- requirements
Module: int_alu_seq

---
 rtl/int_alu_pkg.sv | 31 +++
 rtl/mul16_seq.sv | 48 ++++
 rtl/int_alu_seq.sv | 151 +++++++++++++++
 tb/tb_int_alu_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_alu_pkg.sv
// Shared definitions for the sequential integer ALU.
// Holds the opcode encoding, the FSM state encoding and the status-flag
// bundle used by int_alu_seq.
package int_alu_pkg;

  localparam int W = 16;

  typedef enum logic [3:0] {
    OP_PASS_R = 4'h0, OP_PASS_S = 4'h1, OP_ADD   = 4'h2, OP_SUB   = 4'h3,
    OP_AND    = 4'h4, OP_OR     = 4'h5, OP_XOR   = 4'h6, OP_NOT_R = 4'h7,
    OP_INC_R  = 4'h8, OP_DEC_R  = 4'h9, OP_SHL_R = 4'hA, OP_SHR_R = 4'hB,
    OP_ASR_R  = 4'hC, OP_CMP    = 4'hD, OP_MUL   = 4'hE, OP_NOP   = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_EXEC = 2'd1, S_MUL = 2'd2, S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic c;
    logic n;
    logic z;
    logic v;
  } flags_t;

  // CMP and NOP leave Y alone and never write the register file.
  function automatic logic writes_y(op_e o);
    return !(o == OP_CMP || o == OP_NOP);
  endfunction

endpackage

// File: rtl/mul16_seq.sv
// 16x16 unsigned shift-add multiplier, one iteration per cycle.
// Ports: clk, reset (async, active-high), load (captures a/b and starts),
//        a, b (operands), busy (high during the 16 iterations),
//        product (32-bit result, valid once busy falls).
module mul16_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic [31:0] product
);

  logic [15:0] a_q;
  logic [31:0] prod_q;   // {partial sum, remaining multiplier bits}
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [16:0] sum_d;

  // Add the multiplicand into the upper half when the current multiplier
  // bit is set; the carry becomes the new MSB on the right shift.
  always_comb begin
    sum_d = {1'b0, prod_q[31:16]} + (prod_q[0] ? {1'b0, a_q} : 17'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      a_q    <= a;
      prod_q <= {16'h0000, b};
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      prod_q <= {sum_d, prod_q[15:1]};
      cnt_q  <= cnt_q + 4'd1;
      if (cnt_q == 4'd15) busy_q <= 1'b0;
    end
  end

  assign busy    = busy_q;
  assign product = prod_q;

endmodule

// File: rtl/int_alu_seq.sv
// Sequential 16-bit integer ALU with a register-file style interface.
// Ports: clk, reset (async, active-high); start/op/R_in/S_in/W_Adr_in request
//        an operation (sampled in IDLE only); busy, done (1-cycle pulse),
//        Y and W_Adr drive the register-file write port with enable we;
//        C/N/Z/V status flags, held between operations.
module int_alu_seq
  import int_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [15:0] R_in,
  input  logic [15:0] S_in,
  input  logic [2:0]  W_Adr_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] Y,
  output logic [2:0]  W_Adr,
  output logic        we,
  output logic        C,
  output logic        N,
  output logic        Z,
  output logic        V
);

  state_e      state_q, state_d;
  op_e         op_q;
  logic [15:0] r_q, s_q, y_q, y_d;
  logic [2:0]  wadr_q;
  flags_t      f_q, f_d;
  logic        accept, update;
  logic        mul_busy;
  logic [31:0] product;

  assign accept = (state_q == S_IDLE) && start;

  mul16_seq u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (accept && (op == OP_MUL)),
    .a       (R_in),
    .b       (S_in),
    .busy    (mul_busy),
    .product (product)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state. MUL covers the 16 iterations plus the cycle that captures
  // the finished product, so done lands 18 edges after acceptance.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = (op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_DONE;
      S_MUL:  if (!mul_busy) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
    we   = (state_q == S_DONE) && writes_y(op_q);
  end

  // ALU: one shared adder for ADD/SUB/CMP/INC/DEC, all as R + B + cin.
  logic [15:0] add_b, res;
  logic        add_cin, cout, ovf;
  logic [16:0] sum17;

  always_comb begin
    add_b   = s_q;
    add_cin = 1'b0;
    unique case (op_q)
      OP_SUB, OP_CMP: begin add_b = ~s_q;    add_cin = 1'b1; end
      OP_INC_R:       begin add_b = 16'h0000; add_cin = 1'b1; end
      OP_DEC_R:       begin add_b = 16'hFFFE; add_cin = 1'b1; end
      default:        ;
    endcase
    sum17 = {1'b0, r_q} + {1'b0, add_b} + {16'h0000, add_cin};

    res  = sum17[15:0];
    cout = 1'b0;
    ovf  = 1'b0;
    unique case (op_q)
      OP_PASS_R: res = r_q;
      OP_PASS_S: res = s_q;
      OP_ADD, OP_SUB, OP_CMP, OP_INC_R, OP_DEC_R: begin
        cout = sum17[16];
        ovf  = (r_q[15] == add_b[15]) && (sum17[15] != r_q[15]);
      end
      OP_AND:   res = r_q & s_q;
      OP_OR:    res = r_q | s_q;
      OP_XOR:   res = r_q ^ s_q;
      OP_NOT_R: res = ~r_q;
      OP_SHL_R: begin res = {r_q[14:0], 1'b0};    cout = r_q[15]; end
      OP_SHR_R: begin res = {1'b0, r_q[15:1]};    cout = r_q[0];  end
      OP_ASR_R: begin res = {r_q[15], r_q[15:1]}; cout = r_q[0];  end
      OP_MUL: begin
        res  = product[15:0];
        cout = |product[31:16];
        ovf  = |product[31:16];
      end
      default: res = y_q;
    endcase

    update = (state_q == S_EXEC) || ((state_q == S_MUL) && !mul_busy);
    y_d = y_q;
    f_d = f_q;
    if (update && (op_q != OP_NOP)) begin
      f_d = '{c: cout, n: res[15], z: (res == 16'h0000), v: ovf};
      if (writes_y(op_q)) y_d = res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      s_q    <= '0;
      op_q   <= OP_NOP;
      wadr_q <= '0;
      y_q    <= '0;
      f_q    <= '0;
    end else begin
      if (accept) begin
        r_q    <= R_in;
        s_q    <= S_in;
        op_q   <= op_e'(op);
        wadr_q <= W_Adr_in;
      end
      y_q <= y_d;
      f_q <= f_d;
    end
  end

  assign Y     = y_q;
  assign W_Adr = wadr_q;
  assign C     = f_q.c;
  assign N     = f_q.n;
  assign Z     = f_q.z;
  assign V     = f_q.v;

endmodule

// File: tb/tb_int_alu_seq.sv
module tb_int_alu_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  op;
  logic [15:0] R_in, S_in;
  logic [2:0]  W_Adr_in;
  logic        busy, done, we, C, N, Z, V;
  logic [15:0] Y;
  logic [2:0]  W_Adr;

  int total = 0;
  int passed = 0;

  // reference architectural state
  logic [15:0] ey;
  logic        ec, en, ez, ev;

  int_alu_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .R_in(R_in), .S_in(S_in),
    .W_Adr_in(W_Adr_in), .busy(busy), .done(done), .Y(Y), .W_Adr(W_Adr),
    .we(we), .C(C), .N(N), .Z(Z), .V(V)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operand values.
  task automatic model(input logic [3:0] o, input logic [15:0] r, input logic [15:0] s);
    int ur, us, sr, ss, t;
    longint p;
    logic [15:0] y;
    logic c, v;
    bit upd, wy;
    ur = int'(r); us = int'(s);
    sr = int'($signed(r)); ss = int'($signed(s));
    upd = 1; wy = 1; c = 0; v = 0; y = 16'h0;
    case (o)
      4'h0: y = r;
      4'h1: y = s;
      4'h2: begin t = ur + us; y = 16'(t); c = (t > 65535);
                  v = ((sr + ss) > 32767) || ((sr + ss) < -32768); end
      4'h3, 4'hD: begin y = 16'(ur - us); c = (ur >= us);
                  v = ((sr - ss) > 32767) || ((sr - ss) < -32768); wy = (o != 4'hD); end
      4'h4: y = r & s;
      4'h5: y = r | s;
      4'h6: y = r ^ s;
      4'h7: y = ~r;
      4'h8: begin t = ur + 1; y = 16'(t); c = (t > 65535); v = (sr == 32767); end
      4'h9: begin y = 16'(ur - 1); c = (ur >= 1); v = (sr == -32768); end
      4'hA: begin y = 16'(ur * 2); c = (ur >= 32768); end
      4'hB: begin y = 16'(ur / 2); c = ((ur % 2) == 1); end
      4'hC: begin y = 16'(sr >>> 1); c = ((ur % 2) == 1); end
      4'hE: begin p = longint'(ur) * longint'(us); y = 16'(p); c = (p >= 65536); v = c; end
      default: upd = 0;
    endcase
    if (upd) begin
      if (wy) ey = y;
      ec = c; ev = v; en = y[15]; ez = (y == 16'h0000);
    end
  endtask

  // Issue one op, optionally hammering start/operands while busy.
  task automatic do_op(input logic [3:0] o, input logic [15:0] r, input logic [15:0] s,
                       input logic [2:0] a, input bit noise, input string tag);
    int lat, exp_lat;
    bit got;
    logic exp_we;
    @(negedge clk);
    op = o; R_in = r; S_in = s; W_Adr_in = a; start = 1;
    model(o, r, s);
    @(posedge clk); lat = 1;
    @(negedge clk); start = 0;
    got = 0;
    while (lat < 40) begin
      if (done === 1'b1) begin got = 1; break; end
      if (noise) begin
        start = 1'($urandom % 2); R_in = 16'($urandom); S_in = 16'($urandom);
        op = 4'($urandom); W_Adr_in = 3'($urandom);
      end
      @(posedge clk); lat++;
      @(negedge clk);
    end
    start = 0;
    exp_lat = (o == 4'hE) ? 18 : 2;
    exp_we = !(o == 4'hD || o == 4'hF);
    total++;
    if (!got || lat != exp_lat) $display("FAIL %s latency: got %0d (done seen=%0d) want %0d", tag, lat, got, exp_lat);
    else passed++;
    total++;
    if ({done, we, W_Adr} !== {1'b1, exp_we, a})
      $display("FAIL %s done/we/wadr: got %b %b %0d want 1 %b %0d", tag, done, we, W_Adr, exp_we, a);
    else passed++;
    total++;
    if ({Y, C, N, Z, V} !== {ey, ec, en, ez, ev})
      $display("FAIL %s result: got Y=%h CNZV=%b%b%b%b want Y=%h CNZV=%b%b%b%b",
               tag, Y, C, N, Z, V, ey, ec, en, ez, ev);
    else passed++;
    @(posedge clk); @(negedge clk);
    total++;
    if ({busy, done, we, W_Adr} !== {3'b000, a})
      $display("FAIL %s idle after done: got busy=%b done=%b we=%b wadr=%0d want 0 0 0 %0d",
               tag, busy, done, we, W_Adr, a);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1; start = 0; op = 0; R_in = 0; S_in = 0; W_Adr_in = 0;
    ey = 0; {ec, en, ez, ev} = 4'b0000;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, we, Y, W_Adr, C, N, Z, V} !== 26'd0)
      $display("FAIL reset_state: got busy=%b done=%b we=%b Y=%h wadr=%0d CNZV=%b%b%b%b want all 0",
               busy, done, we, Y, W_Adr, C, N, Z, V);
    else passed++;
    reset = 0;
  endtask

  task automatic test_add();
    do_op(4'h2, 16'h7FFF, 16'h0001, 3'd3, 0, "add_ovf");
    total++;
    if ({Y, N, V, C, Z} !== {16'h8000, 4'b1100})
      $display("FAIL add_ovf_const: got Y=%h NVCZ=%b%b%b%b want 8000 1100", Y, N, V, C, Z);
    else passed++;
  endtask

  task automatic test_cmp();
    logic [15:0] yprev;
    yprev = ey;
    do_op(4'hD, 16'h0005, 16'h0005, 3'd6, 0, "cmp_eq");
    total++;
    if ({Y, Z, C} !== {yprev, 2'b11})
      $display("FAIL cmp_eq_const: got Y=%h Z=%b C=%b want %h 1 1", Y, Z, C, yprev);
    else passed++;
  endtask

  task automatic test_mul();
    do_op(4'hE, 16'h0100, 16'h0300, 3'd5, 1, "mul_ovf");
    total++;
    if ({Y, C, V} !== {16'h0000, 2'b11})
      $display("FAIL mul_ovf_const: got Y=%h C=%b V=%b want 0000 1 1", Y, C, V);
    else passed++;
    do_op(4'hE, 16'h00FF, 16'h0101, 3'd1, 1, "mul_small");
  endtask

  task automatic test_shifts();
    do_op(4'hB, 16'h0001, 16'h1234, 3'd2, 0, "shr");
    total++;
    if ({Y, C, Z} !== {16'h0000, 2'b11})
      $display("FAIL shr_const: got Y=%h C=%b Z=%b want 0000 1 1", Y, C, Z);
    else passed++;
    do_op(4'hC, 16'h8000, 16'h0000, 3'd4, 0, "asr");
    total++;
    if ({Y, C, N} !== {16'hC000, 2'b01})
      $display("FAIL asr_const: got Y=%h C=%b N=%b want c000 0 1", Y, C, N);
    else passed++;
    do_op(4'hA, 16'h8001, 16'h0000, 3'd7, 0, "shl");
    do_op(4'hF, 16'hFFFF, 16'hFFFF, 3'd0, 0, "nop");
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    @(negedge clk);
    op = 4'hE; R_in = 16'h1234; S_in = 16'h5678; W_Adr_in = 3'd7; start = 1;
    @(posedge clk);
    @(negedge clk); start = 0;
    repeat (8) @(posedge clk);
    #2 reset = 1;
    #1;
    ey = 0; {ec, en, ez, ev} = 4'b0000;
    total++;
    if ({busy, done, we, Y, W_Adr, C, N, Z, V} !== 26'd0)
      $display("FAIL reset_mid_mul: got busy=%b done=%b we=%b Y=%h wadr=%0d CNZV=%b%b%b%b want all 0",
               busy, done, we, Y, W_Adr, C, N, Z, V);
    else passed++;
    @(negedge clk); reset = 0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1 || we === 1'b1 || busy === 1'b1) seen = 1;
    end
    total++;
    if (seen) $display("FAIL no_done_after_abort: got activity=1 want 0");
    else passed++;
    do_op(4'h2, 16'h0002, 16'h0003, 3'd1, 0, "add_after_reset");
    total++;
    if (Y !== 16'h0005) $display("FAIL add_after_reset_const: got Y=%h want 0005", Y);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  o;
    logic [15:0] r, s;
    logic [2:0]  a;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (busy !== 1'b0) $display("FAIL b2b_idle%0d: got busy=%b want 0", k, busy);
      else passed++;
      o = 4'($urandom_range(0, 13)); r = 16'($urandom); s = 16'($urandom); a = 3'($urandom);
      op = o; R_in = r; S_in = s; W_Adr_in = a; start = 1;
      model(o, r, s);
      @(posedge clk); @(negedge clk);
      total++;
      if ({busy, done} !== 2'b10) $display("FAIL b2b_exec%0d: got busy=%b done=%b want 1 0", k, busy, done);
      else passed++;
      @(posedge clk); @(negedge clk);
      total++;
      if ({busy, done, W_Adr, Y, C, N, Z, V} !== {2'b11, a, ey, ec, en, ez, ev})
        $display("FAIL b2b_done%0d op=%h: got busy=%b done=%b wadr=%0d Y=%h CNZV=%b%b%b%b want 1 1 %0d %h %b%b%b%b",
                 k, o, busy, done, W_Adr, Y, C, N, Z, V, a, ey, ec, en, ez, ev);
      else passed++;
      @(posedge clk); @(negedge clk);
    end
    start = 0;
  endtask

  task automatic test_random();
    logic [3:0] o;
    for (int i = 0; i < 30; i++) begin
      o = 4'($urandom);
      do_op(o, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom % 2), "random");
    end
    // boundary operands for the flag logic
    do_op(4'h8, 16'hFFFF, 16'h0000, 3'd2, 0, "inc_wrap");
    do_op(4'h9, 16'h8000, 16'h0000, 3'd3, 0, "dec_ovf");
    do_op(4'h3, 16'h0000, 16'h0001, 3'd4, 0, "sub_borrow");
    do_op(4'hE, 16'hFFFF, 16'hFFFF, 3'd5, 0, "mul_max");
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_mul();
    test_shifts();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
